// File: rtl/cpu_ctrl_fsm_p.sv
// Instruction-sequencing control unit for the bus datapath: one instruction per handshake,
// one-hot register/bus strobes, ALU controls. Optional HALT opcode under CPU_FSM_HALT_EN.
module cpu_ctrl_fsm_p #(
   parameter  int REG_ADDR_W = 3,
   parameter  int OP_W       = 4,
   localparam int INSTR_W    = OP_W + 2*REG_ADDR_W,
   localparam int NUM_REGS   = 2**REG_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [INSTR_W-1:0]  instruction,
   input  logic                instr_valid,
   output logic                instr_ready,
   output logic [NUM_REGS-1:0] reg_en,
   output logic [NUM_REGS-1:0] reg_tri,
   output logic                extern_tri,
   output logic                alu_a_en,
   output logic                alu_g_en,
   output logic                alu_g_tri,
   output logic [1:0]          alu_op,
   output logic                done,
   output logic                illegal_op
);

`ifdef CPU_FSM_HALT_EN
   typedef enum logic [3:0] {IDLE, LOAD, MOVE, ALU1, ALU2, ALU3, ILL, HALT_DN, HALT} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, MOVE, ALU1, ALU2, ALU3, ILL} state_t;
`endif

   state_t               state, nxt;
   logic [INSTR_W-1:0]   instr_q;
   logic [OP_W-1:0]      op_q;
   logic [REG_ADDR_W-1:0] x, y;
   logic                 ready_st, accept;

   assign op_q = instr_q[INSTR_W-1 -: OP_W];
   assign x    = instr_q[2*REG_ADDR_W-1:REG_ADDR_W];
   assign y    = instr_q[REG_ADDR_W-1:0];

   // First execute state for an incoming opcode
   function automatic state_t dec(input logic [OP_W-1:0] op);
      state_t s;
      s = ILL;
      if (op == OP_W'(0))                         s = LOAD;
      else if (op == OP_W'(1))                    s = MOVE;
      else if (op >= OP_W'(2) && op <= OP_W'(5))  s = ALU1;
`ifdef CPU_FSM_HALT_EN
      else if (op == OP_W'(15))                   s = HALT_DN;
`endif
      return s;
   endfunction

   // Ready in IDLE and in every retiring cycle, so issue can be back-to-back
   assign ready_st    = (state == IDLE) || (state == LOAD) || (state == MOVE) || (state == ALU3);
   assign instr_ready = ready_st && rst;
   assign accept      = instr_valid && instr_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         instr_q <= '0;
      end else begin
         state <= nxt;
         if (accept) instr_q <= instruction;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:             if (accept) nxt = dec(instruction[INSTR_W-1 -: OP_W]);
         LOAD, MOVE, ALU3: nxt = accept ? dec(instruction[INSTR_W-1 -: OP_W]) : IDLE;
         ALU1:             nxt = ALU2;
         ALU2:             nxt = ALU3;
         ILL:              nxt = IDLE;
`ifdef CPU_FSM_HALT_EN
         HALT_DN:          nxt = HALT;
         HALT:             nxt = HALT;
`endif
         default:          nxt = IDLE;
      endcase
   end

   always_comb begin
      reg_en     = '0;
      reg_tri    = '0;
      extern_tri = 1'b0;
      alu_a_en   = 1'b0;
      alu_g_en   = 1'b0;
      alu_g_tri  = 1'b0;
      alu_op     = 2'b00;
      done       = 1'b0;
      illegal_op = 1'b0;
      case (state)
         LOAD: begin
            reg_en     = NUM_REGS'(1) << x;
            extern_tri = 1'b1;
            done       = 1'b1;
         end
         MOVE: begin
            // Self-move is a no-op on the bus but still retires
            if (x != y) begin
               reg_en  = NUM_REGS'(1) << x;
               reg_tri = NUM_REGS'(1) << y;
            end
            done = 1'b1;
         end
         ALU1: begin
            reg_tri  = NUM_REGS'(1) << x;
            alu_a_en = 1'b1;
         end
         ALU2: begin
            reg_tri  = NUM_REGS'(1) << y;
            alu_g_en = 1'b1;
            case (op_q[2:0])
               3'd3:    alu_op = 2'b10;
               3'd4:    alu_op = 2'b01;
               3'd5:    alu_op = 2'b11;
               default: alu_op = 2'b00;
            endcase
         end
         ALU3: begin
            alu_g_tri = 1'b1;
            reg_en    = NUM_REGS'(1) << x;
            done      = 1'b1;
         end
         ILL: illegal_op = 1'b1;
`ifdef CPU_FSM_HALT_EN
         HALT_DN: done = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm_p.sv
// Directed-vector bench for cpu_ctrl_fsm_p at default parameters (8 registers, 4-bit opcode).
module tb_cpu_ctrl_fsm_p;
   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] instruction;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] reg_en, reg_tri;
   logic       extern_tri, alu_a_en, alu_g_en, alu_g_tri, done, illegal_op;
   logic [1:0] alu_op;
   int         n_chk  = 0;
   int         n_pass = 0;

   cpu_ctrl_fsm_p dut (
      .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .reg_en(reg_en), .reg_tri(reg_tri),
      .extern_tri(extern_tri), .alu_a_en(alu_a_en), .alu_g_en(alu_g_en),
      .alu_g_tri(alu_g_tri), .alu_op(alu_op), .done(done), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic exp_out(input string tag, input logic rdy, input logic [7:0] ren,
                          input logic [7:0] rtri, input logic ext, input logic aen,
                          input logic gen, input logic gtri, input logic [1:0] op,
                          input logic dn, input logic ill);
      chk({tag, ".ready"},   32'(instr_ready), 32'(rdy));
      chk({tag, ".reg_en"},  32'(reg_en),      32'(ren));
      chk({tag, ".reg_tri"}, 32'(reg_tri),     32'(rtri));
      chk({tag, ".ext"},     32'(extern_tri),  32'(ext));
      chk({tag, ".a_en"},    32'(alu_a_en),    32'(aen));
      chk({tag, ".g_en"},    32'(alu_g_en),    32'(gen));
      chk({tag, ".g_tri"},   32'(alu_g_tri),   32'(gtri));
      chk({tag, ".op"},      32'(alu_op),      32'(op));
      chk({tag, ".done"},    32'(done),        32'(dn));
      chk({tag, ".ill"},     32'(illegal_op),  32'(ill));
   endtask

   function automatic logic [9:0] mk(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y);
      return {op, x, y};
   endfunction

   // Advance to next falling edge, apply inputs, let outputs settle
   task automatic step(input logic v, input logic [9:0] ins);
      @(negedge clk);
      instr_valid = v;
      instruction = ins;
      #1;
   endtask

   task automatic run_alu(input string tag, input logic [3:0] op, input logic [2:0] x,
                          input logic [2:0] y, input logic [1:0] eop);
      step(1'b1, mk(op, x, y));
      exp_out({tag, ".idle"}, 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
      step(1'b0, mk(4'd0, ~x, ~y));  // input churn must not disturb the op
      exp_out({tag, ".alu1"}, 0, 8'h00, 8'h01 << x, 0, 1, 0, 0, 2'b00, 0, 0);
      step(1'b0, 10'h3FF);
      exp_out({tag, ".alu2"}, 0, 8'h00, 8'h01 << y, 0, 0, 1, 0, eop, 0, 0);
      step(1'b0, 10'h000);
      exp_out({tag, ".alu3"}, 1, 8'h01 << x, 8'h00, 0, 0, 0, 1, 2'b00, 1, 0);
   endtask

   initial begin
      rst = 1'b0; instr_valid = 1'b0; instruction = '0;
      #2;
      exp_out("rst", 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
      @(negedge clk); rst = 1'b1; #1;
      exp_out("rel", 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);

      // LOAD R3
      step(1'b1, mk(4'd0, 3'd3, 3'd0));
      step(1'b0, 10'h2AA);
      exp_out("load", 1, 8'h08, 8'h00, 1, 0, 0, 0, 2'b00, 1, 0);
      step(1'b0, 10'h000);
      exp_out("load.idle", 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);

      run_alu("add", 4'd2, 3'd1, 3'd5, 2'b00);
      run_alu("sub", 4'd4, 3'd6, 3'd6, 2'b01);
      run_alu("and", 4'd5, 3'd7, 3'd0, 2'b11);

      // Back-to-back MOVE R2,R4 then XOR R0,R7
      step(1'b0, 10'h000);
      step(1'b1, mk(4'd1, 3'd2, 3'd4));
      step(1'b1, mk(4'd3, 3'd0, 3'd7));
      exp_out("b2b.move", 1, 8'h04, 8'h10, 0, 0, 0, 0, 2'b00, 1, 0);
      step(1'b0, 10'h000);
      exp_out("b2b.alu1", 0, 8'h00, 8'h01, 0, 1, 0, 0, 2'b00, 0, 0);
      step(1'b0, 10'h000);
      exp_out("b2b.alu2", 0, 8'h00, 8'h80, 0, 0, 1, 0, 2'b10, 0, 0);
      step(1'b0, 10'h000);
      exp_out("b2b.alu3", 1, 8'h01, 8'h00, 0, 0, 0, 1, 2'b00, 1, 0);
      step(1'b0, 10'h000);
      exp_out("b2b.idle", 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);

      // MOVE R3,R3 suppresses strobes but retires
      step(1'b1, mk(4'd1, 3'd3, 3'd3));
      step(1'b0, 10'h000);
      exp_out("move_self", 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 0);

      // Illegal 4'b1010
      step(1'b1, mk(4'd10, 3'd1, 3'd2));
      step(1'b1, mk(4'd0, 3'd1, 3'd0));
      exp_out("ill", 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1);
      step(1'b0, 10'h000);
      exp_out("ill.idle", 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);

`ifdef CPU_FSM_HALT_EN
      step(1'b1, mk(4'd15, 3'd0, 3'd0));
      step(1'b1, mk(4'd0, 3'd1, 3'd0));
      exp_out("halt", 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, mk(4'd0, 3'd1, 3'd0));
         exp_out("halt.hold", 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
      end
      @(negedge clk); rst = 1'b0; #1;
      @(negedge clk); rst = 1'b1; instr_valid = 1'b0; #1;
      exp_out("halt.rel", 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
`else
      step(1'b1, mk(4'd15, 3'd0, 3'd0));
      step(1'b0, 10'h000);
      exp_out("f_ill", 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1);
      step(1'b0, 10'h000);
      exp_out("f_ill.idle", 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
`endif

      // Reset asserted in the middle of ALU2
      step(1'b1, mk(4'd2, 3'd1, 3'd5));
      step(1'b0, 10'h000);
      step(1'b0, 10'h000);
      exp_out("mid.alu2", 0, 8'h00, 8'h20, 0, 0, 1, 0, 2'b00, 0, 0);
      #2 rst = 1'b0; #1;
      exp_out("mid.rst", 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
      @(negedge clk); rst = 1'b1; #1;
      exp_out("mid.rel", 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
      step(1'b0, 10'h000);
      exp_out("mid.nodone", 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
